// File: rtl/cdc_frame_reader.sv
// Read-domain frame decoder: pops SYNC/LEN/payload/CSUM bytes from the CDC FIFO and streams the payload out.
// Optional saturating frame/drop statistics are enabled with CDC_FRAME_READER_STATS_EN.
module cdc_frame_reader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 255
) (
  input  logic        rclk,
  input  logic        rrst,
  input  logic [7:0]  rdata,
  input  logic        rrdy,
  output logic        rget,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        frame_done,
`ifdef CDC_FRAME_READER_STATS_EN
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt,
`endif
  output logic        frame_err
);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  r_csum;
  logic        r_first;
  logic        w_len_bad;

  assign w_len_bad = (rdata == 8'd0) || ({24'd0, rdata} > MAX_LEN);

`ifdef CDC_FRAME_READER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Payload pops only when the single output register is free or draining this cycle.
  always_comb begin
    rget = 1'b0;
    if (!rrst) begin
      case (r_state)
        S_PAYLOAD: rget = rrdy & (~out_valid | out_ready);
        default:   rget = rrdy;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rget) begin
      case (r_state)
        S_HUNT:    if (rdata == SYNC_BYTE) w_state_nxt = S_LEN;
        S_LEN:     w_state_nxt = w_len_bad ? S_HUNT : S_PAYLOAD;
        S_PAYLOAD: if (r_cnt == 8'd1) w_state_nxt = S_CSUM;
        S_CSUM:    w_state_nxt = S_HUNT;
        default:   w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state    <= S_HUNT;
      r_cnt      <= 8'd0;
      r_csum     <= 8'd0;
      r_first    <= 1'b0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef CDC_FRAME_READER_STATS_EN
      ok_cnt     <= 16'd0;
      err_cnt    <= 16'd0;
      drop_cnt   <= 16'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (rget) begin
            if (w_len_bad) begin
              frame_err <= 1'b1;
            end else begin
              r_cnt   <= rdata;
              r_csum  <= rdata;
              r_first <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (rget) begin
            out_data  <= rdata;
            out_valid <= 1'b1;
            out_sop   <= r_first;
            out_eop   <= (r_cnt == 8'd1);
            r_first   <= 1'b0;
            r_csum    <= r_csum ^ rdata;
            r_cnt     <= r_cnt - 8'd1;
          end
        end
        S_CSUM: begin
          if (rget) begin
            frame_done <= (rdata == r_csum);
            frame_err  <= (rdata != r_csum);
          end
        end
        default: begin
`ifdef CDC_FRAME_READER_STATS_EN
          if (rget && (rdata != SYNC_BYTE)) drop_cnt <= sat_inc(drop_cnt);
`endif
        end
      endcase
`ifdef CDC_FRAME_READER_STATS_EN
      if (frame_done) ok_cnt  <= sat_inc(ok_cnt);
      if (frame_err)  err_cnt <= sat_inc(err_cnt);
`endif
    end
  end

endmodule

// File: tb/tb_cdc_frame_reader.sv
// Bench for cdc_frame_reader: FIFO model, stream-level frame parser as reference, per-cycle output scoreboard.
module tb_cdc_frame_reader;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;

  logic       clk = 1'b0;
  logic       rrst = 1'b1;
  logic [7:0] rdata = 8'd0;
  logic       rrdy = 1'b0;
  logic       rget;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_sop, out_eop, frame_done, frame_err;
`ifdef CDC_FRAME_READER_STATS_EN
  logic [15:0] ok_cnt, err_cnt, drop_cnt;
  logic [15:0] drop_base;
`endif

  cdc_frame_reader dut (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rrdy(rrdy), .rget(rget),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done),
`ifdef CDC_FRAME_READER_STATS_EN
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  bq_t        fifo;
  beat_t      exp_q [$];
  bit         st_q [$];
  int         n_chk = 0, n_fail = 0;
  int         n_pops = 0, n_beats = 0, n_done = 0, n_err = 0;
  logic       r_p = 1'b0;
  logic [7:0] last_pop = 8'd0;
  logic       ready_ctl = 1'b1;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: walk the byte stream frame by frame and list what must come out.
  task automatic parse(input bq_t s);
    int i;
    int len;
    logic [7:0] sum;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
      end else begin
        i++;
        if (i >= s.size()) break;
        len = int'(s[i]);
        i++;
        if (len == 0 || len > 255) begin
          st_q.push_back(1'b0);
        end else begin
          if (i + len >= s.size()) break;
          sum = 8'(len);
          for (int k = 0; k < len; k++) begin
            exp_q.push_back({s[i+k], k == 0, k == len - 1});
            sum = sum ^ s[i+k];
          end
          st_q.push_back(s[i+len] == sum);
          i = i + len + 1;
        end
      end
    end
  endtask

  task automatic feed(input bq_t s, input bit do_parse);
    foreach (s[k]) fifo.push_back(s[k]);
    if (do_parse) parse(s);
  endtask

  task automatic apply();
    rrdy      = (fifo.size() > 0);
    rdata     = rrdy ? fifo[0] : 8'd0;
    out_ready = ready_ctl;
    #1;
    r_p = rget && rrdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (r_p) begin
      last_pop = fifo.pop_front();
      n_pops++;
    end
    #1;
    apply();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((fifo.size() > 0 || out_valid || exp_q.size() > 0 || st_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(n < 300, {nm, " drain timeout"}, n, 300);
    chk(exp_q.size() == 0, {nm, " beats left"}, exp_q.size(), 0);
    chk(st_q.size() == 0, {nm, " status left"}, st_q.size(), 0);
  endtask

  // Scoreboard: sampled mid-cycle, so these values are what the next posedge sees.
  logic       prev_hold = 1'b0;
  beat_t      held;
  always @(negedge clk) begin
    beat_t b;
    bit    s;
    if (rrst) begin
      prev_hold = 1'b0;
    end else begin
      chk(!(rget && !rrdy), "rget without rrdy", rget, 0);
      if (prev_hold)
        chk(out_valid && ({out_data, out_sop, out_eop} == held), "hold stable",
            {out_valid, out_data, out_sop, out_eop}, {1'b1, held});
      if (out_valid && out_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected beat", {out_data, out_sop, out_eop}, 0);
        end else begin
          b = exp_q.pop_front();
          chk({out_data, out_sop, out_eop} == b, "beat", {out_data, out_sop, out_eop}, b);
        end
      end
      if (frame_done || frame_err) begin
        n_done += int'(frame_done);
        n_err  += int'(frame_err);
        if (st_q.size() == 0) begin
          chk(1'b0, "unexpected status", {frame_done, frame_err}, 0);
        end else begin
          s = st_q.pop_front();
          chk((frame_done == s) && (frame_err == !s), "status", {frame_done, frame_err}, {s, !s});
        end
      end
      prev_hold = out_valid && !out_ready;
      held      = {out_data, out_sop, out_eop};
    end
  end

  initial begin
    bq_t s;
    int  n;

    // Reset: rget stays low even with data waiting.
    s = {8'h00};
    feed(s, 1'b1);
    apply();
    repeat (3) tick();
    chk(rget == 1'b0, "reset rget", rget, 0);
    chk({out_valid, out_sop, out_eop, frame_done, frame_err} == 5'b0, "reset flags",
        {out_valid, out_sop, out_eop, frame_done, frame_err}, 0);
    chk(out_data == 8'd0, "reset out_data", out_data, 0);
    chk(n_pops == 0, "reset pops", n_pops, 0);
    rrst = 1'b0;
    apply();
    drain("warmup");

    // Good frame, with literal pins on the reference.
    n_pops = 0; n_beats = 0; n_done = 0; n_err = 0;
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(s, 1'b1);
    chk(exp_q.size() == 3, "model beat count", exp_q.size(), 3);
    chk(exp_q[0] == {8'h11, 1'b1, 1'b0}, "model first beat", exp_q[0], {8'h11, 1'b1, 1'b0});
    chk(exp_q[2] == {8'h33, 1'b0, 1'b1}, "model last beat", exp_q[2], {8'h33, 1'b0, 1'b1});
    chk(st_q[0] == 1'b1, "model good status", st_q[0], 1);
    drain("good");
    chk(n_pops == 6, "good pops", n_pops, 6);
    chk(n_beats == 3, "good beats", n_beats, 3);
    chk(n_done == 1 && n_err == 0, "good status count", {n_done[3:0], n_err[3:0]}, 8'h10);

    // Bad checksum.
    n_beats = 0; n_done = 0; n_err = 0;
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    feed(s, 1'b1);
    chk(st_q[0] == 1'b0, "model bad status", st_q[0], 0);
    drain("badcsum");
    chk(n_beats == 3, "badcsum beats", n_beats, 3);
    chk(n_done == 0 && n_err == 1, "badcsum status count", {n_done[3:0], n_err[3:0]}, 8'h01);

    // Resync over junk bytes.
    n_beats = 0; n_done = 0;
`ifdef CDC_FRAME_READER_STATS_EN
    drop_base = drop_cnt;
`endif
    s = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(s, 1'b1);
    drain("resync");
    chk(n_beats == 3 && n_done == 1, "resync decode", {n_beats[3:0], n_done[3:0]}, 8'h31);
`ifdef CDC_FRAME_READER_STATS_EN
    chk(drop_cnt - drop_base == 16'd3, "drop_cnt", drop_cnt - drop_base, 3);
`endif

    // Bad length followed by a one-byte frame.
    n_beats = 0; n_done = 0; n_err = 0;
    s = {8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    feed(s, 1'b1);
    chk(exp_q.size() == 1 && exp_q[0] == {8'h7E, 1'b1, 1'b1}, "model len1 beat", exp_q[0], {8'h7E, 1'b1, 1'b1});
    drain("badlen");
    chk(n_beats == 1 && n_done == 1 && n_err == 1, "badlen counts",
        {n_beats[3:0], n_done[3:0], n_err[3:0]}, 12'h111);

    // Backpressure on the first payload byte.
    n_beats = 0;
    ready_ctl = 1'b0;
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(s, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk(n < 20, "bp first byte timeout", n, 20);
    for (int c = 0; c < 5; c++) begin
      chk(rget == 1'b0, "bp rget", rget, 0);
      chk(out_valid && out_data == 8'h11 && out_sop, "bp held byte", {out_valid, out_data, out_sop}, 10'h223);
      tick();
    end
    ready_ctl = 1'b1;
    drain("backpressure");
    chk(n_beats == 3, "bp beats", n_beats, 3);

    // Reset right after byte 22 is popped.
    n_beats = 0; n_done = 0; n_err = 0;
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(s, 1'b0);
    exp_q.push_back({8'h11, 1'b1, 1'b0});
    n = 0;
    last_pop = 8'h00;
    while (last_pop != 8'h22 && n < 20) begin tick(); n++; end
    chk(n < 20, "rst wait timeout", n, 20);
    rrst = 1'b1;
    ready_ctl = 1'b0;
    apply();
    tick();
    rrst = 1'b0;
    ready_ctl = 1'b1;
    apply();
    chk({out_valid, out_sop, out_eop, frame_done, frame_err} == 5'b0, "midrst flags",
        {out_valid, out_sop, out_eop, frame_done, frame_err}, 0);
    chk(out_data == 8'd0, "midrst out_data", out_data, 0);
    chk(n_beats == 1 && exp_q.size() == 0, "midrst beats before", n_beats, 1);
    chk(fifo.size() == 2, "midrst fifo untouched", fifo.size(), 2);
    s = {8'h33, 8'h03, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    parse(s);
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(s, 1'b0);
    drain("midrst");
    chk(n_beats == 4 && n_done == 1 && n_err == 0, "midrst after",
        {n_beats[3:0], n_done[3:0], n_err[3:0]}, 12'h410);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_frame_reader.md
Name: cdc_frame_reader

Overview:
- Read-side consumer for the CDC sync FIFO. Lives entirely in the read clock domain.
- Pops bytes from the FIFO read interface (rdata/rrdy/rget) and decodes framed packets: SYNC, LEN, payload, CSUM.
- Forwards payload bytes downstream over a valid/ready stream with sop/eop markers.
- Reports per-frame good/bad status after the checksum byte.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 255, largest legal LEN value (1..255). LEN=0 or LEN>MAX_LEN is a frame error.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  synchronous, active-high reset.
- rdata  in  8  FIFO read data; valid while rrdy=1.
- rrdy  in  1  FIFO non-empty.
- rget  out  1  FIFO pop; a transfer occurs on a posedge where rrdy&rget=1.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept; a transfer occurs when out_valid&out_ready.
- out_sop  out  1  qualifies the first payload byte of a frame.
- out_eop  out  1  qualifies the last payload byte of a frame.
- frame_done  out  1  one-cycle pulse: frame ended with a good checksum.
- frame_err  out  1  one-cycle pulse: frame ended with a bad checksum or a bad LEN.

Behaviour:
- Interface is decided: one clock (rclk); reset rrst is synchronous and active-high.
- Reset values:
  - out_valid, out_sop, out_eop, frame_done, frame_err = 0; out_data = 0.
  - state = HUNT; checksum accumulator = 0; byte counter = 0.
  - rget = 0 while rrst=1.
- rget is combinational from state, rrdy, out_valid and out_ready. It never asserts when rrdy=0.
- State machine:
  - HUNT: rget=rrdy. A popped byte equal to SYNC_BYTE → LEN. Any other byte is discarded and the FSM stays in HUNT.
  - LEN: rget=rrdy. On pop:
    - byte=0 or byte>MAX_LEN → pulse frame_err next cycle, → HUNT.
    - otherwise load count=byte, csum=byte → PAYLOAD.
  - PAYLOAD: rget = rrdy & (!out_valid | out_ready), a single output register stage with full throughput.
    - On pop: out_data<=byte, out_valid<=1, csum^=byte, count--.
    - out_sop=1 on the first payload byte; out_eop=1 when count reaches 0.
    - After the last byte → CSUM.
  - CSUM: rget=rrdy. On pop, compare byte with csum. The next cycle pulses frame_done on a match, else frame_err. → HUNT.
- Output stage:
  - out_data/out_sop/out_eop hold stable while out_valid=1 and out_ready=0.
  - out_valid clears after a transfer unless a new byte is popped on the same edge.
- Latency: a payload byte popped at edge N is on out_data with out_valid=1 from edge N until accepted.
- Max throughput: one byte per cycle in every state.
- CSUM may be popped while the last payload byte is still pending downstream. The status pulse can therefore precede acceptance of the eop byte.
- Checksum: 8-bit XOR of LEN and all payload bytes.
- Reset mid-frame: all state clears immediately.
  - A pending output byte is dropped.
  - No eop or status is emitted for the aborted frame.
  - FIFO contents are untouched, and HUNT resumes after reset.
- Simultaneous output transfer and new pop in PAYLOAD: the register reloads and out_valid stays 1.

Optional Feature:
- Macro CDC_FRAME_READER_STATS_EN.
- When defined, adds three output ports, all cleared by rrst:
  - ok_cnt (16-bit): increments on frame_done, saturates at 16'hFFFF.
  - err_cnt (16-bit): increments on frame_err, saturates at 16'hFFFF.
  - drop_cnt (16-bit): increments per non-SYNC byte discarded in HUNT, saturates at 16'hFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Good frame: FIFO holds A5 03 11 22 33 03, out_ready=1 → out bytes 11(sop), 22, 33(eop), frame_done pulse once, frame_err=0, 6 pops total.
- Bad checksum: A5 03 11 22 33 04 → same three payload bytes out, frame_err pulse, frame_done=0, FSM back in HUNT.
- Resync: 00 FF 5A then a good frame → three bytes discarded with no output, good frame decoded normally; drop_cnt=3 when STATS_EN is defined.
- Bad length: A5 00 A5 01 7E 7F → first frame gives frame_err and no output; second frame gives out 7E with sop&eop, then frame_done.
- Backpressure: good frame with out_ready held 0 for 5 cycles after the first payload byte → rget=0 throughout, out_data=11 held stable; resumes at full rate with no loss or duplication.
- Reset mid-payload: assert rrst for 1 cycle after byte 22 of A5 03 11 22 33 03 → all outputs 0, no eop/status; remaining 33 03 discarded in HUNT; a following good frame decodes correctly.
